// File: rtl/fpu_mul_pkg.sv
// -----------------------------------------------------------------------------
// fpu_mul_pkg
// Shared definitions for the FPU multiplier datapath: mantissa/exponent
// widths, exponent bias, the iterative multiplier state encoding and an
// IEEE-754 single-precision field view.
// -----------------------------------------------------------------------------
package fpu_mul_pkg;

  localparam int MANT_W   = 24;            // mantissa width including hidden bit
  localparam int EXP_W    = 8;             // exponent field width
  localparam int BIAS     = 127;           // exponent bias
  localparam int PROD_W   = 2 * MANT_W;    // full mantissa product width
  localparam int EXP_SUM_W = EXP_W + 2;    // signed exponent sum width
  localparam int CNT_W    = 5;             // iteration counter width

  // Multiplier sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ZERO = 2'd2,
    DONE = 2'd3
  } state_t;

  // IEEE-754 single-precision field layout
  typedef struct packed {
    logic                 sign;
    logic [EXP_W-1:0]     exp;
    logic [MANT_W-2:0]    frac;
  } fp32_t;

endpackage : fpu_mul_pkg

// File: rtl/fp_exp_adder.sv
// -----------------------------------------------------------------------------
// fp_exp_adder
// Combinational exponent path of the multiplier: adds two biased exponent
// fields, removes one bias and saturates the result.
//
// Ports:
//   exp_a, exp_b : biased exponent fields of the two operands
//   exp_res      : biased result exponent (255 on overflow, 0 on underflow)
//   ovf          : result exponent >= 255
//   unf          : result exponent <= 0
// -----------------------------------------------------------------------------
module fp_exp_adder
  import fpu_mul_pkg::*;
(
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  output logic [EXP_W-1:0] exp_res,
  output logic             ovf,
  output logic             unf
);

  localparam logic signed [EXP_SUM_W-1:0] BIAS_S  = EXP_SUM_W'(BIAS);
  localparam logic signed [EXP_SUM_W-1:0] E_MAX_S = 10'sd255;
  localparam logic signed [EXP_SUM_W-1:0] E_MIN_S = 10'sd0;

  logic signed [EXP_SUM_W-1:0] e_sum_s;

  // Signed exponent sum with one bias removed; range -125..383 fits in 10 bits
  always_comb begin
    e_sum_s = signed'({2'b00, exp_a}) + signed'({2'b00, exp_b}) - BIAS_S;
  end

  // Saturate to the representable biased range
  always_comb begin
    exp_res = {EXP_W{1'b0}};
    ovf     = 1'b0;
    unf     = 1'b0;
    if (e_sum_s >= E_MAX_S) begin
      exp_res = {EXP_W{1'b1}};
      ovf     = 1'b1;
    end else if (e_sum_s <= E_MIN_S) begin
      exp_res = {EXP_W{1'b0}};
      unf     = 1'b1;
    end else begin
      exp_res = e_sum_s[EXP_W-1:0];
    end
  end

endmodule : fp_exp_adder

// File: rtl/fp_mantissa_multiplier.sv
// -----------------------------------------------------------------------------
// fp_mantissa_multiplier
// Iterative shift-add mantissa multiplier feeding the normalizer. Inserts the
// hidden bits, builds the 48-bit product one multiplier bit per cycle (24
// cycles), adds exponents with bias removal and XORs the signs. Operands with
// a zero exponent field (zero/denormal) bypass the multiply through ZERO.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready only in IDLE)
//   a, b                : IEEE-754 single operands
//   out_valid/out_ready : result handshake; outputs held while out_ready low
//   sign                : a[31] ^ b[31]
//   fraction            : product[47:24] (bit 23 set means product >= 2.0)
//   exponent            : biased exponent before normalization
//   zero, ovf, unf      : zero result, saturated overflow, flushed underflow
//   sticky, guard       : OR of product[23:0] and product[23]; present only
//                         when FP_MANT_MUL_STICKY_EN is defined
// -----------------------------------------------------------------------------
module fp_mantissa_multiplier
  import fpu_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign,
  output logic [MANT_W-1:0] fraction,
  output logic [EXP_W-1:0]  exponent,
  output logic              zero,
  output logic              ovf,
  output logic              unf
`ifdef FP_MANT_MUL_STICKY_EN
  ,
  output logic              sticky,
  output logic              guard
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = 5'd23;

  state_t              state_r, state_nxt_s;
  fp32_t               a_in_s, b_in_s;
  fp32_t               a_r, b_r;
  logic [MANT_W-1:0]   ma_r, mb_r;
  logic [PROD_W-1:0]   acc_r, acc_nxt_s;
  logic [MANT_W-1:0]   addend_s;
  logic [MANT_W:0]     sum_s;
  logic [CNT_W-1:0]    count_r;
  logic                last_iter_s;

  logic [EXP_W-1:0]    exp_res_s;
  logic                exp_ovf_s, exp_unf_s;

  logic                in_ready_r, out_valid_r;
  logic                sign_r, zero_r, ovf_r, unf_r;
  logic [MANT_W-1:0]   fraction_r;
  logic [EXP_W-1:0]    exponent_r;
`ifdef FP_MANT_MUL_STICKY_EN
  logic                sticky_r, guard_r;
`endif

  assign a_in_s      = fp32_t'(a);
  assign b_in_s      = fp32_t'(b);
  assign last_iter_s = (count_r == LAST_CNT);

  fp_exp_adder u_exp_adder (
    .exp_a   (a_r.exp),
    .exp_b   (b_r.exp),
    .exp_res (exp_res_s),
    .ovf     (exp_ovf_s),
    .unf     (exp_unf_s)
  );

  // One shift-add step: conditionally add ma into the upper half, carry into acc[47]
  always_comb begin
    addend_s  = mb_r[0] ? ma_r : {MANT_W{1'b0}};
    sum_s     = {1'b0, acc_r[PROD_W-1:MANT_W]} + {1'b0, addend_s};
    acc_nxt_s = {sum_s, acc_r[MANT_W-1:1]};
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if ((a_in_s.exp == {EXP_W{1'b0}}) || (b_in_s.exp == {EXP_W{1'b0}})) begin
            state_nxt_s = ZERO;
          end else begin
            state_nxt_s = CALC;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (last_iter_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CALC;
        end
      end
      ZERO: begin
        state_nxt_s = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register and handshake flags, registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Operand capture, multiplier shift register, accumulator and iteration count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      ma_r    <= {MANT_W{1'b0}};
      mb_r    <= {MANT_W{1'b0}};
      acc_r   <= {PROD_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a_in_s;
            b_r     <= b_in_s;
            ma_r    <= {1'b1, a_in_s.frac};
            mb_r    <= {1'b1, b_in_s.frac};
            acc_r   <= {PROD_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
          end
        end
        CALC: begin
          acc_r   <= acc_nxt_s;
          mb_r    <= {1'b0, mb_r[MANT_W-1:1]};
          count_r <= count_r + 5'd1;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Result registers, loaded only on entry to DONE so they stay frozen there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r     <= 1'b0;
      fraction_r <= {MANT_W{1'b0}};
      exponent_r <= {EXP_W{1'b0}};
      zero_r     <= 1'b0;
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
`ifdef FP_MANT_MUL_STICKY_EN
      sticky_r   <= 1'b0;
      guard_r    <= 1'b0;
`endif
    end else if ((state_r == CALC) && last_iter_s) begin
      sign_r     <= a_r.sign ^ b_r.sign;
      exponent_r <= exp_res_s;
      zero_r     <= 1'b0;
      ovf_r      <= exp_ovf_s;
      unf_r      <= exp_unf_s;
      // Underflow flushes the mantissa so the normalizer sees a clean zero
      fraction_r <= exp_unf_s ? {MANT_W{1'b0}} : acc_nxt_s[PROD_W-1:MANT_W];
`ifdef FP_MANT_MUL_STICKY_EN
      sticky_r   <= exp_unf_s ? 1'b0 : (|acc_nxt_s[MANT_W-1:0]);
      guard_r    <= exp_unf_s ? 1'b0 : acc_nxt_s[MANT_W-1];
`endif
    end else if (state_r == ZERO) begin
      sign_r     <= a_r.sign ^ b_r.sign;
      fraction_r <= {MANT_W{1'b0}};
      exponent_r <= {EXP_W{1'b0}};
      zero_r     <= 1'b1;
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
`ifdef FP_MANT_MUL_STICKY_EN
      sticky_r   <= 1'b0;
      guard_r    <= 1'b0;
`endif
    end else begin
      sign_r     <= sign_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sign      = sign_r;
  assign fraction  = fraction_r;
  assign exponent  = exponent_r;
  assign zero      = zero_r;
  assign ovf       = ovf_r;
  assign unf       = unf_r;
`ifdef FP_MANT_MUL_STICKY_EN
  assign sticky    = sticky_r;
  assign guard     = guard_r;
`endif

endmodule : fp_mantissa_multiplier
